// File: rtl/image_output_reader.sv
// Raster-order frame readback from the image BRAM, with lane-mask highlight overlay,
// streamed into the output FIFO under full-flag backpressure with a one-pixel skid hold.
module image_output_reader #(
    parameter int          WIDTH           = 1280,
    parameter int          HEIGHT          = 720,
    parameter int          IMAGE_SIZE      = WIDTH * HEIGHT,
    parameter logic [23:0] HIGHLIGHT_COLOR = 24'hFF0000,
    localparam int         AW              = $clog2(IMAGE_SIZE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] bram_rd_addr,
    input  logic [23:0]   bram_rd_data,
    input  logic          mask_rd_data,
    output logic          out_wr_en,
    input  logic          out_full,
    output logic [23:0]   out_din
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(IMAGE_SIZE - 1);

    typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

    state_t        state;
    logic [AW-1:0] addr;
    logic          rd_valid;
    logic          hold_valid;
    logic [23:0]   hold_px;
    logic          done_q;
    logic          issue;
    logic [23:0]   px;

    // A read is only issued when the FIFO can take the returning pixel and the skid slot is empty.
    assign issue        = (state == READ) && !out_full && !hold_valid;
    assign px           = mask_rd_data ? HIGHLIGHT_COLOR : bram_rd_data;
    assign bram_rd_addr = (state == READ) ? addr : '0;
    assign busy         = (state != IDLE);
    assign done         = done_q;

    always_comb begin
        out_wr_en = 1'b0;
        out_din   = '0;
        if (hold_valid && !out_full) begin
            out_wr_en = 1'b1;
            out_din   = hold_px;
        end else if (rd_valid && !out_full) begin
            out_wr_en = 1'b1;
            out_din   = px;
        end
    end

    // Skid data register carries no reset; hold_valid qualifies it.
    always_ff @(posedge clock) begin
        if (rd_valid && out_full)
            hold_px <= px;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            rd_valid   <= 1'b0;
            hold_valid <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            rd_valid <= issue;
            if (hold_valid && !out_full)
                hold_valid <= 1'b0;
            else if (rd_valid && out_full)
                hold_valid <= 1'b1;
            case (state)
                IDLE: begin
                    // A start landing on the done cycle is dropped.
                    if (start && !done_q) begin
                        state <= READ;
                        addr  <= '0;
                    end
                end
                READ: begin
                    if (issue) begin
                        if (addr == LAST_ADDR)
                            state <= FLUSH;
                        else
                            addr <= addr + 1'b1;
                    end
                end
                FLUSH: begin
                    if ((rd_valid || hold_valid) && !out_full) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    addr       <= '0;
                    rd_valid   <= 1'b0;
                    hold_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_output_reader.sv
// Directed bench for image_output_reader on an 8x4 frame; BRAM model returns data = address.
module tb_image_output_reader;

    localparam int WIDTH  = 8;
    localparam int HEIGHT = 4;
    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int AW     = $clog2(NPIX);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] bram_rd_addr;
    logic [23:0]   bram_rd_data = '0;
    logic          mask_rd_data = 1'b0;
    logic          out_wr_en;
    logic          out_full = 1'b0;
    logic [23:0]   out_din;

    logic          mask [NPIX];
    logic [23:0]   exp_q [$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            done_cnt = 0;

    image_output_reader #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .HIGHLIGHT_COLOR(24'hFF0000)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data), .mask_rd_data(mask_rd_data),
        .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din)
    );

    always #5 clock = ~clock;

    // One-cycle read latency BRAMs
    always @(posedge clock) begin
        bram_rd_data <= {{(24-AW){1'b0}}, bram_rd_addr};
        mask_rd_data <= mask[bram_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every FIFO write pops the next expected pixel
    always @(negedge clock) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (out_wr_en) begin
                chk("no_write_when_full", {31'b0, out_full}, 32'd0);
                if (exp_q.size() == 0)
                    chk("unexpected_write", {8'b0, out_din}, 32'hFFFFFFFF);
                else
                    chk("pixel", {8'b0, out_din}, {8'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic push_frame();
        for (int i = 0; i < NPIX; i++)
            exp_q.push_back(mask[i] ? 24'hFF0000 : 24'(i));
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic end_frame(input string tag);
        chk({tag, "_drained"}, exp_q.size(), 32'd0);
        chk({tag, "_one_done"}, done_cnt, 32'd1);
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic wait_done(input bit toggle, input int budget);
        int  n = 0;
        bit  seen = 0;
        while (!seen && n < budget) begin
            cyc();
            if (toggle) out_full = ~out_full;
            @(negedge clock);
            if (done) seen = 1;
            n++;
        end
        chk("done_within_budget", {31'b0, seen}, 32'd1);
        cyc();
        out_full = 1'b0;
    endtask

    // Start at cycle 0 with out_full low and check cycle-exact timing; optional re-start pulse.
    task automatic frame_timed(input int restart_cyc);
        push_frame();
        start = 1'b1;
        @(negedge clock);
        for (int k = 1; k <= 34; k++) begin
            cyc();
            start = (k == restart_cyc) ? 1'b1 : 1'b0;
            @(negedge clock);
            chk($sformatf("busy_c%0d", k), {31'b0, busy}, {31'b0, (k <= 33)});
            chk($sformatf("done_c%0d", k), {31'b0, done}, {31'b0, (k == 34)});
            chk($sformatf("wr_c%0d", k), {31'b0, out_wr_en}, {31'b0, (k >= 2 && k <= 33)});
            if (k <= 32) chk($sformatf("addr_c%0d", k), {27'b0, bram_rd_addr}, k - 1);
        end
        cyc();
        start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_wr"}, {31'b0, out_wr_en}, 32'd0);
        chk({tag, "_din"}, {8'b0, out_din}, 32'd0);
        chk({tag, "_addr"}, {27'b0, bram_rd_addr}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) mask[i] = 1'b0;
        #2;
        check_idle_outputs("reset");
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        cyc();

        // 1: free-running frame, exact timing
        frame_timed(-1);
        end_frame("t1");

        // 2: out_full toggling every cycle
        push_frame();
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done(1'b1, 400);
        end_frame("t2");

        // 3: lane-mask overlay at pixels 5 and 17
        mask[5]  = 1'b1;
        mask[17] = 1'b1;
        push_frame();
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done(1'b0, 100);
        end_frame("t3");
        mask[5]  = 1'b0;
        mask[17] = 1'b0;

        // 4: ten cycles of backpressure right after address 12 issues
        begin
            bit found = 0;
            push_frame();
            start = 1'b1;
            cyc();
            start = 1'b0;
            for (int n = 0; n < 100 && !found; n++) begin
                @(negedge clock);
                if (busy && bram_rd_addr == 12) found = 1;
                else cyc();
            end
            chk("t4_addr12_seen", {31'b0, found}, 32'd1);
            for (int n = 0; n < 10; n++) begin
                cyc();
                out_full = 1'b1;
            end
            cyc();
            out_full = 1'b0;
            @(negedge clock);
            chk("t4_release_wr", {31'b0, out_wr_en}, 32'd1);
            chk("t4_release_px", {8'b0, out_din}, 32'd12);
            wait_done(1'b0, 100);
            end_frame("t4");
        end

        // 5: second start while busy is ignored
        frame_timed(10);
        repeat (5) begin
            @(negedge clock);
            chk("t5_stays_idle", {31'b0, busy}, 32'd0);
        end
        end_frame("t5");

        // 6: reset mid-frame, then a clean frame
        begin
            bit found = 0;
            push_frame();
            cyc();
            start = 1'b1;
            cyc();
            start = 1'b0;
            for (int n = 0; n < 100 && !found; n++) begin
                @(negedge clock);
                if (busy && bram_rd_addr == 20) found = 1;
                else cyc();
            end
            chk("t6_addr20_seen", {31'b0, found}, 32'd1);
            #2 reset = 1'b1;
            #1;
            check_idle_outputs("t6_mid_reset");
            repeat (2) @(posedge clock);
            #1 reset = 1'b0;
            exp_q.delete();
            done_cnt = 0;
            repeat (40) cyc();
            chk("t6_no_done", done_cnt, 32'd0);
            chk("t6_no_stray_writes", exp_q.size(), 32'd0);
            frame_timed(-1);
            end_frame("t6");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
